// File: rtl/button_conditioner.sv
// Input conditioner for active-low push-buttons.
// Each button is synchronised, debounced and turned into a clean active-high
// level plus single-cycle press, release and optional auto-repeat pulses.
//
// Ports:
//   Clk           system clock
//   Reset         synchronous, active-high reset
//   Btn_n         raw active-low button pins, asynchronous to Clk
//   Pressed       debounced level, 1 while the button is accepted as held
//   Press_pulse   1-cycle pulse in the cycle Pressed rises
//   Release_pulse 1-cycle pulse in the cycle Pressed falls
//   Repeat_pulse  1-cycle auto-repeat pulse while held (REPEAT_EN bits only)
module button_conditioner #(
  parameter int unsigned      N_BTN        = 4,
  parameter int unsigned      DEBOUNCE_CYC = 500000,
  parameter int unsigned      REPEAT_DLY   = 25000000,
  parameter int unsigned      REPEAT_PER   = 5000000,
  parameter logic [N_BTN-1:0] REPEAT_EN    = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [N_BTN-1:0] Btn_n,
  output logic [N_BTN-1:0] Pressed,
  output logic [N_BTN-1:0] Press_pulse,
  output logic [N_BTN-1:0] Release_pulse,
  output logic [N_BTN-1:0] Repeat_pulse
);

  localparam int unsigned   DB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_e;

  logic [N_BTN-1:0] sync1_q, sync1_d;
  logic [N_BTN-1:0] sync2_q, sync2_d;
  logic [N_BTN-1:0] raw_p;
  logic [N_BTN-1:0] pressed_q, pressed_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [N_BTN-1:0] repeat_q, repeat_d;

  // Two-flop synchroniser; flops idle at 1 (button released).
  always_comb begin
    sync1_d = Btn_n;
    sync2_d = sync1_q;
  end

  assign raw_p = ~sync2_q;

  // Edge pulses are derived from the next stable level so they line up with Pressed.
  always_comb begin
    press_d   = pressed_d & ~pressed_q;
    release_d = ~pressed_d & pressed_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      pressed_q <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  genvar i;
  for (i = 0; i < N_BTN; i++) begin : g_btn
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            stable_d;

    // Debounce: accept a new level only after DEBOUNCE_CYC consecutive disagreeing samples.
    always_comb begin
      cnt_d    = cnt_q;
      stable_d = pressed_q[i];
      if (raw_p[i] == pressed_q[i]) begin
        cnt_d = '0;
      end else if (cnt_q == DB_LAST) begin
        stable_d = raw_p[i];
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end

    always_ff @(posedge Clk) begin
      if (Reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign pressed_d[i] = stable_d;

    if (REPEAT_EN[i]) begin : g_rpt
      localparam int unsigned RPT_MAX  = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
      localparam int unsigned RC_W     = $clog2(RPT_MAX + 1);
      localparam logic [RC_W-1:0] DLY_LAST = RC_W'(REPEAT_DLY - 1);
      localparam logic [RC_W-1:0] PER_LAST = RC_W'(REPEAT_PER - 1);

      rpt_state_e      state_q, state_d;
      logic [RC_W-1:0] rcnt_q, rcnt_d;
      logic            rpt_d;

      // Auto-repeat sequencer; a falling level cancels any pending pulse.
      always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rpt_d   = 1'b0;
        if (!stable_d) begin
          state_d = RPT_IDLE;
          rcnt_d  = '0;
        end else begin
          case (state_q)
            RPT_IDLE: begin
              if (!pressed_q[i]) begin
                state_d = RPT_DELAY;
                rcnt_d  = '0;
              end
            end
            RPT_DELAY: begin
              if (rcnt_q == DLY_LAST) begin
                rpt_d   = 1'b1;
                state_d = RPT_REPEAT;
                rcnt_d  = '0;
              end else begin
                rcnt_d = rcnt_q + RC_W'(1);
              end
            end
            RPT_REPEAT: begin
              if (rcnt_q == PER_LAST) begin
                rpt_d  = 1'b1;
                rcnt_d = '0;
              end else begin
                rcnt_d = rcnt_q + RC_W'(1);
              end
            end
            default: begin
              state_d = RPT_IDLE;
              rcnt_d  = '0;
            end
          endcase
        end
      end

      always_ff @(posedge Clk) begin
        if (Reset) begin
          state_q <= RPT_IDLE;
          rcnt_q  <= '0;
        end else begin
          state_q <= state_d;
          rcnt_q  <= rcnt_d;
        end
      end

      assign repeat_d[i] = rpt_d;
    end else begin : g_no_rpt
      assign repeat_d[i] = 1'b0;
    end
  end

  assign Pressed       = pressed_q;
  assign Press_pulse   = press_q;
  assign Release_pulse = release_q;
  assign Repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed stimulus, a reference model feeding
// an expected-output queue each cycle, plus fixed-latency spot checks.
module tb_button_conditioner;

  localparam int unsigned N_BTN = 4;
  localparam int unsigned DB    = 4;
  localparam int unsigned DLY   = 10;
  localparam int unsigned PER   = 3;
  localparam logic [3:0]  EN    = 4'b0010;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [3:0] Btn_n;
  logic [3:0] Pressed, Press_pulse, Release_pulse, Repeat_pulse;

  always #5 Clk = ~Clk;

  button_conditioner #(
    .N_BTN        (N_BTN),
    .DEBOUNCE_CYC (DB),
    .REPEAT_DLY   (DLY),
    .REPEAT_PER   (PER),
    .REPEAT_EN    (EN)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Btn_n         (Btn_n),
    .Pressed       (Pressed),
    .Press_pulse   (Press_pulse),
    .Release_pulse (Release_pulse),
    .Repeat_pulse  (Repeat_pulse)
  );

  typedef struct packed {
    logic [3:0] pr;
    logic [3:0] pp;
    logic [3:0] rp;
    logic [3:0] rt;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   edge_n  = 0;

  // Reference model state: sync pipeline, per-button sample window, stable level.
  logic [3:0]    m_s1, m_s2, m_s;
  logic [DB-1:0] m_win [4];
  int            m_press_edge [4];

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @edge %0d: observed %b expected %b", tag, edge_n, obs, exp);
    end
  endtask

  // Window formulation: level flips once the last DB samples all disagree with it.
  task automatic model_edge(input logic rst, input logic [3:0] btn_n, input int e_idx,
                            output exp_t e);
    logic [3:0] raw;
    logic       old_s, new_s;
    int         d;
    e = '0;
    if (rst) begin
      m_s1 = '0;
      m_s2 = '0;
      m_s  = '0;
      for (int b = 0; b < 4; b++) m_win[b] = '0;
    end else begin
      raw  = m_s2;
      m_s2 = m_s1;
      m_s1 = ~btn_n;
      for (int b = 0; b < 4; b++) begin
        m_win[b] = {m_win[b][DB-2:0], raw[b]};
        old_s = m_s[b];
        new_s = old_s;
        if (!old_s && (m_win[b] == '1)) new_s = 1'b1;
        else if (old_s && (m_win[b] == '0)) new_s = 1'b0;
        e.pr[b] = new_s;
        e.pp[b] = new_s & ~old_s;
        e.rp[b] = ~new_s & old_s;
        if (new_s && !old_s) m_press_edge[b] = e_idx;
        if (EN[b] && new_s && old_s) begin
          d = e_idx - m_press_edge[b];
          if (d == int'(DLY) || (d > int'(DLY) && ((d - int'(DLY)) % int'(PER)) == 0))
            e.rt[b] = 1'b1;
        end
        m_s[b] = new_s;
      end
    end
  endtask

  // One clock: push the model's prediction, advance, pop and compare.
  task automatic step();
    exp_t e, got;
    model_edge(Reset, Btn_n, edge_n + 1, e);
    sb_q.push_back(e);
    @(posedge Clk);
    edge_n++;
    #1;
    got = sb_q.pop_front();
    chk("pressed",       Pressed,       got.pr);
    chk("press_pulse",   Press_pulse,   got.pp);
    chk("release_pulse", Release_pulse, got.rp);
    chk("repeat_pulse",  Repeat_pulse,  got.rt);
    chk("press_release_excl", Press_pulse & Release_pulse, 4'b0000);
  endtask

  initial begin
    int         t0;
    logic [3:0] acc;

    // Reset state
    Reset = 1'b1;
    Btn_n = 4'hF;
    repeat (3) step();
    chk("reset_all", Pressed | Press_pulse | Release_pulse | Repeat_pulse, 4'b0000);
    Reset = 1'b0;
    repeat (2) step();

    // Clean press and release on bit 0
    Btn_n[0] = 1'b0;
    t0 = edge_n;
    repeat (5) step();
    chk("press0_early", Press_pulse, 4'b0000);
    step();
    chk("press0_pulse", Press_pulse, 4'b0001);
    chk("press0_level", Pressed, 4'b0001);
    step();
    chk("press0_single", Press_pulse, 4'b0000);
    while (edge_n < t0 + 20) step();
    Btn_n[0] = 1'b1;
    repeat (5) step();
    chk("release0_early", Release_pulse, 4'b0000);
    step();
    chk("release0_pulse", Release_pulse, 4'b0001);
    chk("release0_level", Pressed, 4'b0000);
    repeat (4) step();

    // Bounce rejection on bit 2
    acc = '0;
    Btn_n[2] = 1'b0;
    repeat (3) begin step(); acc |= {Pressed[2], Press_pulse[2], Release_pulse[2], Repeat_pulse[2]}; end
    Btn_n[2] = 1'b1;
    step(); acc |= {Pressed[2], Press_pulse[2], Release_pulse[2], Repeat_pulse[2]};
    Btn_n[2] = 1'b0;
    repeat (3) begin step(); acc |= {Pressed[2], Press_pulse[2], Release_pulse[2], Repeat_pulse[2]}; end
    Btn_n[2] = 1'b1;
    repeat (10) begin step(); acc |= {Pressed[2], Press_pulse[2], Release_pulse[2], Repeat_pulse[2]}; end
    chk("bounce2_quiet", acc, 4'b0000);

    // Auto-repeat: bit 1 enabled, bit 3 masked
    Btn_n[1] = 1'b0;
    Btn_n[3] = 1'b0;
    t0 = edge_n;
    repeat (6) step();
    chk("rpt_press", Press_pulse, 4'b1010);
    for (int k = 7; k <= 25; k++) begin
      step();
      chk("rpt_timing", Repeat_pulse, (k >= 16 && ((k - 16) % 3) == 0) ? 4'b0010 : 4'b0000);
    end
    Btn_n[1] = 1'b1;
    Btn_n[3] = 1'b1;
    acc = '0;
    repeat (15) begin
      step();
      if (!Pressed[1]) acc[0] = acc[0] | Repeat_pulse[1];
      acc[1] = acc[1] | Repeat_pulse[3];
    end
    chk("rpt_after_release", acc, 4'b0000);
    repeat (4) step();

    // Simultaneous press on bits 0 and 3, release only bit 0
    Btn_n[0] = 1'b0;
    Btn_n[3] = 1'b0;
    repeat (6) step();
    chk("simul_press", Press_pulse, 4'b1001);
    repeat (4) step();
    Btn_n[0] = 1'b1;
    repeat (6) step();
    chk("simul_release", Release_pulse, 4'b0001);
    chk("simul_level", Pressed, 4'b1000);

    // Reset while bits 0 and 3 are held, then re-press after reset
    Btn_n[0] = 1'b0;
    repeat (8) step();
    chk("pre_reset_level", Pressed, 4'b1001);
    Reset = 1'b1;
    step();
    chk("mid_reset_outs", Pressed | Press_pulse | Release_pulse | Repeat_pulse, 4'b0000);
    Reset = 1'b0;
    repeat (5) step();
    chk("rearm_early", Press_pulse, 4'b0000);
    step();
    chk("rearm_press", Press_pulse, 4'b1001);

    // Reset held with random pin activity
    Reset = 1'b1;
    repeat (20) begin
      Btn_n = 4'($urandom);
      step();
      chk("reset_hold", Pressed | Press_pulse | Release_pulse | Repeat_pulse, 4'b0000);
    end
    Reset = 1'b0;
    Btn_n = 4'hF;
    repeat (8) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input-side conditioner for the board's active-low push-buttons. It sits between the raw key pins and the control logic that consumes Reset/LoadB/Run-style buttons.
- Per button, it synchronises the raw input, debounces it, and produces a clean active-high level plus single-cycle press, release and auto-repeat pulses.
- Downstream logic samples these clean signals instead of raw pins.

Parameters:
- N_BTN, 4, number of independent buttons.
- DEBOUNCE_CYC, 500000, consecutive stable cycles required to accept a change (10 ms at 50 MHz); must be >= 1.
- REPEAT_DLY, 25000000, cycles from Pressed rising to the first Repeat_pulse; must be >= 1.
- REPEAT_PER, 5000000, cycles between subsequent Repeat_pulses; must be >= 1.
- REPEAT_EN, {N_BTN{1'b0}}, per-button auto-repeat enable mask.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset  in  1  synchronous, active-high reset.
- Btn_n  in  N_BTN  raw push-button inputs, active low, asynchronous to Clk.
- Pressed  out  N_BTN  debounced level, 1 while the button is accepted as held.
- Press_pulse  out  N_BTN  1-cycle pulse on accepted press.
- Release_pulse  out  N_BTN  1-cycle pulse on accepted release.
- Repeat_pulse  out  N_BTN  1-cycle auto-repeat pulse while held (REPEAT_EN bits only).

Behaviour:
- One clock (Clk). Reset is synchronous and active-high. All outputs are registered.
- Reset:
  - All outputs 0; all counters 0; synchroniser flops loaded with 1 (released).
  - Reset asserted mid-press: outputs 0 the following cycle, no Release_pulse.
  - A button still held when Reset deasserts is treated as a new press.
- Synchroniser: 2 flops per bit, so sampled value raw_p = ~sync2. 2-cycle latency.
- Debounce, per button:
  - Stable state S (drives Pressed).
  - Counter cnt, width $clog2(DEBOUNCE_CYC+1).
  - If raw_p == S: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYC-1: S <= raw_p and cnt <= 0.
  - Else: cnt <= cnt+1.
- Latency: a change held steady from clock edge t takes effect on Pressed at edge t+2+DEBOUNCE_CYC.
- Glitches: any glitch shorter than DEBOUNCE_CYC cycles produces no output change, and the counter restarts on every bounce.
- Pulses:
  - Press_pulse is 1 exactly in the cycle Pressed goes 0->1.
  - Release_pulse is 1 exactly in the cycle Pressed goes 1->0.
  - Never both at once for the same bit.
- Repeat, per button with REPEAT_EN[i]=1. FSM states:
  - IDLE: Pressed=0. On Press_pulse -> DELAY, rcnt <= 0.
  - DELAY: rcnt increments each cycle; when it reaches REPEAT_DLY-1, Repeat_pulse is asserted next cycle -> REPEAT, rcnt <= 0.
  - REPEAT: rcnt increments; at REPEAT_PER-1, Repeat_pulse is asserted next cycle, rcnt <= 0.
  - Any state, Pressed falls -> IDLE, rcnt <= 0, no further Repeat_pulse.
- Repeat timing and widths:
  - First Repeat_pulse occurs REPEAT_DLY cycles after the Press_pulse cycle; subsequent pulses every REPEAT_PER cycles.
  - Press_pulse and Repeat_pulse never coincide.
  - rcnt width is sized for max(REPEAT_DLY, REPEAT_PER).
- Buttons with REPEAT_EN[i]=0: Repeat_pulse[i] is tied 0 and their repeat logic is optimised away.
- Buttons are fully independent; simultaneous events on different bits are each handled per the rules above.
- Counters never wrap; they saturate by the reset-on-match rules above.

Test Plan:
Common bench parameters: N_BTN=4, DEBOUNCE_CYC=4, REPEAT_DLY=10, REPEAT_PER=3, REPEAT_EN=4'b0010.
- Clean press: Btn_n[0] driven low at edge 0 and held -> Pressed[0]=1 and Press_pulse[0]=1 at edge 6; Press_pulse[0]=0 at edge 7. Then release at edge 20 -> Release_pulse[0]=1 and Pressed[0]=0 at edge 26.
- Bounce rejection: Btn_n[2] low 3 cycles, high 1, low 3, high -> Pressed[2], Press_pulse[2] and Release_pulse[2] stay 0 throughout.
- Auto-repeat: Btn_n[1] held low from edge 0 -> Press_pulse[1] at edge 6; Repeat_pulse[1] at edges 16, 19, 22, ...; release -> no Repeat_pulse after Pressed[1] falls. Same stimulus on bit 3 -> Repeat_pulse[3] never asserts.
- Simultaneous: Btn_n[0] and Btn_n[3] low on the same edge -> both Press_pulses at edge 6. Btn_n[0] released while bit 3 stays held -> only Release_pulse[0].
- Reset mid-press: Pressed[0]=1, then Reset=1 for one cycle -> all outputs 0 next cycle, no Release_pulse. With Btn_n[0] still low -> Press_pulse[0] reasserts at 2+DEBOUNCE_CYC=6 edges after Reset deasserts.
- Reset value: Reset held with random Btn_n toggling -> all four outputs remain 0 every cycle.
